instr_sequencer: RTL and testbench

- Fetch/issue controller for the 32-entry x 32-bit instruction memory.
- Owns the PC and drives the memory's 5-bit address. Latches each instruction word into an instruction register (IR), decodes the 2-bit opcode and hands decoded fields to the datapath with a valid/ready handshake.
- Waits for the datapath's completion before advancing. Sits between the instruction memory and the execution datapath.

---
 rtl/instr_sequencer_pkg.sv | 33 +++
 rtl/instr_decode.sv | 22 ++
 rtl/instr_sequencer.sv | 149 ++++++++++++++
 tb/tb_instr_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, the fixed 32-bit
// field layout and the FSM state encoding.
package instr_sequencer_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_W    = 2;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 15;

    localparam int OP_LSB   = 30;
    localparam int RS_A_LSB = 25;
    localparam int RS_B_LSB = 20;
    localparam int RD_LSB   = 15;
    localparam int IMM_LSB  = 0;

    localparam logic [OP_W-1:0] OP_A    = 2'b00;
    localparam logic [OP_W-1:0] OP_B    = 2'b01;
    localparam logic [OP_W-1:0] OP_C    = 2'b10;
    localparam logic [OP_W-1:0] OP_HALT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        EXEC,
        HALT
    } state_t;

    function automatic logic op_is_halt(input logic [OP_W-1:0] op_code);
        return op_code == OP_HALT;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational field extraction from the instruction register, plus a flag
// marking the HALT opcode.
module instr_decode
    import instr_sequencer_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic [OP_W-1:0]    op,
    output logic [REG_W-1:0]   rs_a,
    output logic [REG_W-1:0]   rs_b,
    output logic [REG_W-1:0]   rd,
    output logic [IMM_W-1:0]   imm,
    output logic               is_halt
);

    assign op      = ir[OP_LSB   +: OP_W];
    assign rs_a    = ir[RS_A_LSB +: REG_W];
    assign rs_b    = ir[RS_B_LSB +: REG_W];
    assign rd      = ir[RD_LSB   +: REG_W];
    assign imm     = ir[IMM_LSB  +: IMM_W];
    assign is_halt = op_is_halt(op);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue controller: owns the PC, latches instruction words into the IR,
// hands decoded fields to the datapath and waits for completion before advancing.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = 5,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    output logic [AW-1:0] mem_addr,
    input  logic [W-1:0]  mem_data,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [1:0]    op,
    output logic [4:0]    rs_a,
    output logic [4:0]    rs_b,
    output logic [4:0]    rd,
    output logic [14:0]   imm,
    input  logic          exec_done,
    output logic          busy,
    output logic          halted,
    output logic [CW-1:0] retired
);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] pc;
    logic [W-1:0]  ir;
    logic [CW-1:0] retired_cnt;
    logic          stop_pend;

    logic          load_ir;
    logic          begin_run;
    logic          advance;
    logic          clear_stop;
    logic          fetch_halt;
    logic          ir_is_halt;

    instr_decode u_decode (
        .ir      (ir),
        .op      (op),
        .rs_a    (rs_a),
        .rs_b    (rs_b),
        .rd      (rd),
        .imm     (imm),
        .is_halt (ir_is_halt)
    );

    assign fetch_halt = op_is_halt(mem_data[OP_LSB +: OP_W]);
    assign mem_addr   = pc;
    assign retired    = retired_cnt;
    assign busy       = (state != IDLE) && (state != HALT);
    assign halted     = (state == HALT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        load_ir     = 1'b0;
        begin_run   = 1'b0;
        advance     = 1'b0;
        clear_stop  = 1'b0;
        issue_valid = 1'b0;

        unique case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_next = FETCH;
                    begin_run  = 1'b1;
                    clear_stop = 1'b1;
                end
            end
            FETCH: begin
                if (stop_pend) begin
                    state_next = IDLE;
                    clear_stop = 1'b1;
                end else begin
                    load_ir    = 1'b1;
                    state_next = fetch_halt ? HALT : ISSUE;
                end
            end
            ISSUE: begin
                // A HALT word never reaches the datapath, even if it sits in IR.
                issue_valid = !ir_is_halt;
                if (issue_valid && issue_ready) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    advance    = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
                clear_stop = 1'b1;
            end
        endcase
    end

    // NOTE: IR is an ordinary register and is reset, so the field outputs are
    // defined from the first cycle rather than carrying X into the datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= '0;
            ir          <= '0;
            retired_cnt <= '0;
            stop_pend   <= 1'b0;
        end else begin
            if (begin_run) begin
                pc <= '0;
            end else if (advance) begin
                pc <= pc + AW'(1);
            end

            if (load_ir) begin
                ir <= mem_data;
            end

            if (begin_run) begin
                retired_cnt <= '0;
            end else if (advance && (retired_cnt != {CW{1'b1}})) begin
                retired_cnt <= retired_cnt + CW'(1);
            end

            if (clear_stop) begin
                stop_pend <= 1'b0;
            end else if (stop && busy) begin
                stop_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a transaction-level model tracks the
// expected PC, retired count and issued words; a CW=2 instance checks saturation.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        issue_ready;
    logic        exec_done;

    logic [31:0] mem [32];

    logic [4:0]  mem_addr,    mem_addr_sat;
    logic [31:0] mem_data,    mem_data_sat;
    logic        issue_valid, issue_valid_sat;
    logic [1:0]  op,          op_sat;
    logic [4:0]  rs_a,        rs_a_sat;
    logic [4:0]  rs_b,        rs_b_sat;
    logic [4:0]  rd,          rd_sat;
    logic [14:0] imm,         imm_sat;
    logic        busy,        busy_sat;
    logic        halted,      halted_sat;
    logic [7:0]  retired;
    logic [1:0]  retired_sat;

    assign mem_data     = mem[mem_addr];
    assign mem_data_sat = mem[mem_addr_sat];

    always #5 clk = ~clk;

    instr_sequencer #(.W(32), .AW(5), .CW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .op(op), .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .imm(imm),
        .exec_done(exec_done), .busy(busy), .halted(halted), .retired(retired)
    );

    instr_sequencer #(.W(32), .AW(5), .CW(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .mem_addr(mem_addr_sat), .mem_data(mem_data_sat),
        .issue_valid(issue_valid_sat), .issue_ready(issue_ready),
        .op(op_sat), .rs_a(rs_a_sat), .rs_b(rs_b_sat), .rd(rd_sat), .imm(imm_sat),
        .exec_done(exec_done), .busy(busy_sat), .halted(halted_sat), .retired(retired_sat)
    );

    int n_checks = 0;
    int n_errors = 0;
    int m_pc;
    int m_retired;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [1:0] o, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] d,
                                       input logic [14:0] i);
        return {o, a, b, d, i};
    endfunction

    function automatic logic [31:0] rand_exec_word();
        logic [1:0] o;
        o = 2'($urandom_range(0, 2));
        return {o, 30'($urandom)};
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 32; i++) mem[i] = rand_exec_word();
    endtask

    task automatic chk_ctl(input string tag, input bit valid, input bit bsy, input bit hlt);
        check({tag, ".valid"},      32'(issue_valid),     32'(valid));
        check({tag, ".busy"},       32'(busy),            32'(bsy));
        check({tag, ".halted"},     32'(halted),          32'(hlt));
        check({tag, ".valid_sat"},  32'(issue_valid_sat), 32'(valid));
        check({tag, ".busy_sat"},   32'(busy_sat),        32'(bsy));
        check({tag, ".halted_sat"}, 32'(halted_sat),      32'(hlt));
    endtask

    task automatic chk_regs(input string tag);
        check({tag, ".pc"},          32'(mem_addr),     32'(m_pc));
        check({tag, ".pc_sat"},      32'(mem_addr_sat), 32'(m_pc));
        check({tag, ".retired"},     32'(retired),      32'(sat(m_retired, 255)));
        check({tag, ".retired_sat"}, 32'(retired_sat),  32'(sat(m_retired, 3)));
    endtask

    task automatic chk_fields(input string tag, input logic [31:0] w);
        logic [31:0] got;
        logic [31:0] got_sat;
        got     = {op, rs_a, rs_b, rd, imm};
        got_sat = {op_sat, rs_a_sat, rs_b_sat, rd_sat, imm_sat};
        check({tag, ".fields"},     got,     w);
        check({tag, ".fields_sat"}, got_sat, w);
    endtask

    task automatic do_reset(input string tag, input bit ready_during);
        rst_n       = 1'b0;
        start       = 1'b1;
        stop        = 1'b0;
        issue_ready = ready_during;
        exec_done   = 1'b0;
        step();
        m_pc      = 0;
        m_retired = 0;
        chk_ctl(tag, 1'b0, 1'b0, 1'b0);
        chk_regs(tag);
        chk_fields(tag, 32'h0);
        step();
        rst_n       = 1'b1;
        start       = 1'b0;
        issue_ready = 1'b0;
        step();
        chk_ctl({tag, "_after"}, 1'b0, 1'b0, 1'b0);
        chk_regs({tag, "_after"});
    endtask

    // Pulses stop while idle (must be ignored), then start; leaves the DUT in FETCH.
    task automatic start_run(input string tag);
        stop = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b1;
        step();
        start     = 1'b0;
        m_pc      = 0;
        m_retired = 0;
        chk_ctl({tag, "_fetch0"}, 1'b0, 1'b1, 1'b0);
        chk_regs({tag, "_fetch0"});
    endtask

    // Entered at a FETCH sample point; runs one instruction through to the next FETCH.
    task automatic exec_instr(input string tag, input int rdy_wait, input int done_wait,
                              input bit stop_req, output bit hit_halt);
        logic [31:0] w;
        w        = mem[m_pc];
        hit_halt = 1'b0;
        chk_regs({tag, "_fetch"});
        step();
        if (w[31:30] == OP_HALT) begin
            hit_halt = 1'b1;
            chk_ctl({tag, "_halt"}, 1'b0, 1'b0, 1'b1);
            chk_regs({tag, "_halt"});
            exec_done = 1'b1;
            step();
            exec_done = 1'b0;
            chk_ctl({tag, "_halt_hold"}, 1'b0, 1'b0, 1'b1);
            chk_regs({tag, "_halt_hold"});
            return;
        end
        chk_ctl({tag, "_issue"}, 1'b1, 1'b1, 1'b0);
        chk_fields({tag, "_issue"}, w);
        for (int i = 0; i < rdy_wait; i++) begin
            issue_ready = 1'b0;
            exec_done   = 1'($urandom_range(0, 1));
            step();
            chk_ctl({tag, "_bp"}, 1'b1, 1'b1, 1'b0);
            chk_fields({tag, "_bp"}, w);
        end
        issue_ready = 1'b1;
        exec_done   = 1'b0;
        step();
        issue_ready = 1'b0;
        chk_ctl({tag, "_exec"}, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < done_wait; i++) begin
            start = 1'($urandom_range(0, 1));
            step();
            start = 1'b0;
            chk_ctl({tag, "_wait"}, 1'b0, 1'b1, 1'b0);
            chk_regs({tag, "_wait"});
        end
        exec_done = 1'b1;
        stop      = stop_req;
        step();
        exec_done = 1'b0;
        stop      = 1'b0;
        m_pc      = (m_pc + 1) % 32;
        m_retired++;
        chk_ctl({tag, "_refetch"}, 1'b0, 1'b1, 1'b0);
        chk_regs({tag, "_refetch"});
        if (stop_req) begin
            step();
            chk_ctl({tag, "_stopped"}, 1'b0, 1'b0, 1'b0);
            chk_regs({tag, "_stopped"});
            chk_fields({tag, "_stopped"}, w);
            step();
            chk_ctl({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bit h;
        int k;
        int n;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; issue_ready = 1'b0; exec_done = 1'b0;
        fill_random();
        do_reset("por", 1'b0);

        // Directed program ending in HALT at address 3
        mem[0] = mk(OP_A,    5'd4, 5'd5, 5'd0, 15'h0443);
        mem[1] = mk(OP_C,    5'd4, 5'd5, 5'd0, 15'h0443);
        mem[2] = mk(OP_B,    5'd4, 5'd5, 5'd0, 15'h0443);
        mem[3] = mk(OP_HALT, 5'd4, 5'd5, 5'd0, 15'h0443);
        start_run("prog");
        for (int i = 0; i < 3; i++) begin
            exec_instr("prog", 0, 0, 1'b0, h);
            check("prog.no_early_halt", 32'(h), 32'd0);
        end
        exec_instr("prog_end", 0, 0, 1'b0, h);
        check("prog.halt_hit", 32'(h), 32'd1);
        check("prog.final_pc", 32'(mem_addr), 32'd3);
        check("prog.final_retired", 32'(retired), 32'd3);

        // Backpressure, then wrap past address 31 with no HALT in memory
        fill_random();
        start_run("wrap");
        exec_instr("bp", 5, 1, 1'b0, h);
        for (int i = 0; i < 32; i++) begin
            exec_instr("wrap", $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, h);
        end
        check("wrap.retired", 32'(retired), 32'd33);
        check("wrap.retired_sat", 32'(retired_sat), 32'd3);
        check("wrap.pc", 32'(mem_addr), 32'd1);
        check("wrap.busy", 32'(busy), 32'd1);
        exec_instr("wrap_stop", 0, 0, 1'b1, h);

        // Stop with exec_done of the PC=2 instruction
        fill_random();
        start_run("stop");
        exec_instr("stop", $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, h);
        exec_instr("stop", $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, h);
        exec_instr("stop_last", 1, 1, 1'b1, h);
        check("stop.retired", 32'(retired), 32'd3);
        check("stop.pc", 32'(mem_addr), 32'd3);

        // Reset in ISSUE at PC=7, with start and ready held during reset
        fill_random();
        start_run("mid");
        for (int i = 0; i < 7; i++) begin
            exec_instr("mid", $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, h);
        end
        step();
        chk_ctl("mid_issue7", 1'b1, 1'b1, 1'b0);
        check("mid_issue7.pc", 32'(mem_addr), 32'd7);
        do_reset("mid_rst", 1'b1);

        // Random program with HALT at a random address
        fill_random();
        k = $urandom_range(2, 10);
        mem[k] = {OP_HALT, 30'($urandom)};
        start_run("rhalt");
        n = 0;
        h = 1'b0;
        while (!h && n < 40) begin
            exec_instr("rhalt", $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, h);
            n++;
        end
        check("rhalt.hit", 32'(h), 32'd1);
        check("rhalt.pc", 32'(mem_addr), 32'(k));
        check("rhalt.retired", 32'(retired), 32'(k));

        // Restart from HALT must clear halted and the counters
        start_run("restart");
        exec_instr("restart", 0, 0, 1'b0, h);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
